// File: rtl/uno_dealer.sv
// uno_dealer: game-level controller sitting between the shuffled deck store
// and the per-player hand/turn logic.
//   - Starts a shuffle, deals HAND_SIZE cards to each player round-robin,
//     then flips the first non-wild card as the opening discard.
//   - Afterwards it arbitrates player draw requests round-robin, handing out
//     one card per grant until the deck runs out.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   i_new_game          pulse; starts a new game from any state
//   o_shuffle_start     one-cycle pulse to the deck store
//   i_shuffle_done      level from the deck store
//   o_deck_addr         combinational read address (= ptr)
//   i_deck_card         card at o_deck_addr, same-cycle read
//   i_draw_req          per-player draw request (held until grant seen)
//   o_draw_gnt          registered one-hot grant pulse
//   o_card_valid/o_card/o_card_player  registered card delivery
//   o_top_valid/o_top_card             opening discard
//   o_busy              high in SHUFFLE, DEAL, FLIP
//   o_deck_empty        high in EMPTY
//   o_cards_left        DECK_SIZE - ptr
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waits for i_new_game
// SHUFFLE | start pulse issued, waits for i_shuffle_done
// DEAL    | one card per cycle to players 0..N-1 in turn
// FLIP    | burns wild cards until a non-wild opening discard is found
// SERVE   | round-robin arbitration of draw requests
// EMPTY   | deck exhausted, waits for i_new_game
module uno_dealer #(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_SIZE   = 7,
    parameter int DECK_SIZE   = 108
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_new_game,
    output logic                   o_shuffle_start,
    input  logic                   i_shuffle_done,
    output logic [6:0]             o_deck_addr,
    input  logic [5:0]             i_deck_card,
    input  logic [NUM_PLAYERS-1:0] i_draw_req,
    output logic [NUM_PLAYERS-1:0] o_draw_gnt,
    output logic                   o_card_valid,
    output logic [5:0]             o_card,
    output logic [1:0]             o_card_player,
    output logic                   o_top_valid,
    output logic [5:0]             o_top_card,
    output logic                   o_busy,
    output logic                   o_deck_empty,
    output logic [6:0]             o_cards_left
);

    localparam int PW         = 2;
    localparam int DEAL_TOTAL = NUM_PLAYERS * HAND_SIZE;
    localparam int CW         = $clog2(DEAL_TOTAL + 1);
    localparam logic [6:0] DECK_END  = 7'(DECK_SIZE);
    localparam logic [6:0] LAST_ADDR = 7'(DECK_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHUFFLE, S_DEAL, S_FLIP, S_SERVE, S_EMPTY
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             ptr_q, ptr_d;
    logic [PW-1:0]          deal_player_q, deal_player_d;
    logic [CW-1:0]          deal_cnt_q, deal_cnt_d;
    logic [PW-1:0]          last_gnt_q, last_gnt_d;
    logic                   shuffle_start_q, shuffle_start_d;
    logic [NUM_PLAYERS-1:0] draw_gnt_q, draw_gnt_d;
    logic                   card_valid_q, card_valid_d;
    logic [5:0]             card_q, card_d;
    logic [1:0]             card_player_q, card_player_d;
    logic                   top_valid_q, top_valid_d;
    logic [5:0]             top_card_q, top_card_d;

    logic [NUM_PLAYERS-1:0] eligible;
    logic                   gnt_found;
    logic [PW-1:0]          gnt_idx;
    logic [PW-1:0]          cand;
    logic [6:0]             ptr_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            deal_player_q   <= '0;
            deal_cnt_q      <= '0;
            last_gnt_q      <= PW'(NUM_PLAYERS - 1);
            shuffle_start_q <= 1'b0;
            draw_gnt_q      <= '0;
            card_valid_q    <= 1'b0;
            card_q          <= '0;
            card_player_q   <= '0;
            top_valid_q     <= 1'b0;
            top_card_q      <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            deal_player_q   <= deal_player_d;
            deal_cnt_q      <= deal_cnt_d;
            last_gnt_q      <= last_gnt_d;
            shuffle_start_q <= shuffle_start_d;
            draw_gnt_q      <= draw_gnt_d;
            card_valid_q    <= card_valid_d;
            card_q          <= card_d;
            card_player_q   <= card_player_d;
            top_valid_q     <= top_valid_d;
            top_card_q      <= top_card_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        deal_player_d   = deal_player_q;
        deal_cnt_d      = deal_cnt_q;
        last_gnt_d      = last_gnt_q;
        shuffle_start_d = 1'b0;
        draw_gnt_d      = '0;
        card_valid_d    = 1'b0;
        card_d          = card_q;
        card_player_d   = card_player_q;
        top_valid_d     = top_valid_q;
        top_card_d      = top_card_q;
        ptr_inc         = ptr_q + 7'd1;

        // The requester just granted still shows its request for a cycle
        // while it reacts; masking it avoids handing it a second card.
        eligible  = i_draw_req & ~draw_gnt_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PLAYERS; k++) begin
            cand = PW'((int'(last_gnt_q) + k) % NUM_PLAYERS);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end

        if (i_new_game) begin
            shuffle_start_d = 1'b1;
            ptr_d           = '0;
            top_valid_d     = 1'b0;
            state_d         = S_SHUFFLE;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_SHUFFLE: begin
                    // a done level seen alongside our own start pulse is stale
                    if (i_shuffle_done && !shuffle_start_q) begin
                        state_d       = S_DEAL;
                        deal_player_d = '0;
                        deal_cnt_d    = '0;
                    end
                end
                S_DEAL: begin
                    if (ptr_q == DECK_END) begin
                        state_d = S_EMPTY;
                    end else begin
                        card_valid_d  = 1'b1;
                        card_d        = i_deck_card;
                        card_player_d = deal_player_q;
                        ptr_d         = ptr_inc;
                        deal_player_d = (deal_player_q == PW'(NUM_PLAYERS - 1)) ?
                                        '0 : deal_player_q + 1'b1;
                        deal_cnt_d    = deal_cnt_q + 1'b1;
                        if (deal_cnt_q == CW'(DEAL_TOTAL - 1))
                            state_d = S_FLIP;
                    end
                end
                S_FLIP: begin
                    if (ptr_q == DECK_END) begin
                        state_d     = S_EMPTY;
                        top_valid_d = 1'b0;
                    end else begin
                        ptr_d = ptr_inc;
                        if (i_deck_card[3:0] >= 4'd13) begin
                            if (ptr_q == LAST_ADDR) begin
                                state_d     = S_EMPTY;
                                top_valid_d = 1'b0;
                            end
                        end else begin
                            top_card_d  = i_deck_card;
                            top_valid_d = 1'b1;
                            state_d     = (ptr_q == LAST_ADDR) ? S_EMPTY : S_SERVE;
                        end
                    end
                end
                S_SERVE: begin
                    if (ptr_q == DECK_END) begin
                        state_d = S_EMPTY;
                    end else if (gnt_found) begin
                        draw_gnt_d[gnt_idx] = 1'b1;
                        card_valid_d        = 1'b1;
                        card_d              = i_deck_card;
                        card_player_d       = gnt_idx;
                        last_gnt_d          = gnt_idx;
                        ptr_d               = ptr_inc;
                        if (ptr_q == LAST_ADDR)
                            state_d = S_EMPTY;
                    end
                end
                S_EMPTY: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_deck_addr     = ptr_q;
    assign o_cards_left    = DECK_END - ptr_q;
    assign o_shuffle_start = shuffle_start_q;
    assign o_draw_gnt      = draw_gnt_q;
    assign o_card_valid    = card_valid_q;
    assign o_card          = card_q;
    assign o_card_player   = card_player_q;
    assign o_top_valid     = top_valid_q;
    assign o_top_card      = top_card_q;
    assign o_busy          = (state_q == S_SHUFFLE) || (state_q == S_DEAL) ||
                             (state_q == S_FLIP);
    assign o_deck_empty    = (state_q == S_EMPTY);

endmodule
